// File: rtl/led_ctrl_pkg.sv
// Shared types for the LED controller: operating modes, scan direction and the configuration record.
// Config fields are carried at a fixed width so one struct serves every PRE_W/PWM_W up to 32 bits.
package led_ctrl_pkg;

    localparam int CFG_W = 32;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_COUNT = 2'd1,
        MODE_PWM   = 2'd2,
        MODE_SCAN  = 2'd3
    } mode_t;

    typedef struct packed {
        mode_t            mode;
        logic [CFG_W-1:0] prescale;
        logic [CFG_W-1:0] duty;
    } cfg_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/led_prescaler.sv
// Prescaler: counts 0..prescale_i and flags tick_o combinationally on the terminal count.
// Latency: restart_i clears the count on the next edge; no backpressure, free-running.
module led_prescaler
    import led_ctrl_pkg::*;
#(
    parameter int PRE_W = 24
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             restart_i,
    input  logic [CFG_W-1:0] prescale_i,
    output logic             tick_o
);

    logic [PRE_W-1:0] pre_cnt_q;
    logic [PRE_W-1:0] pre_cnt_d;

    // The terminal value is zero-extended, so comparing at full width is exact.
    assign tick_o = (CFG_W'(pre_cnt_q) == prescale_i);

    always_comb begin
        pre_cnt_d = pre_cnt_q + PRE_W'(1);
        if (restart_i || tick_o) begin
            pre_cnt_d = '0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pre_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
        end
    end

endmodule

// File: rtl/led_ctrl.sv
// LED controller: OFF/COUNT/PWM/SCAN patterns stepped by a prescaler tick; led is registered one cycle after state.
// Backpressure: cfg_ready drops after a transfer and returns the cycle after the pending config is applied.
module led_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int N_LEDS  = 8,
    parameter int PRE_W   = 24,
    parameter int PWM_W   = 8,
    parameter int PRE_RST = 2**16-1
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [1:0]        cfg_mode,
    input  logic [PRE_W-1:0]  cfg_prescale,
    input  logic [PWM_W-1:0]  cfg_duty,
    output logic              tick,
    output logic [N_LEDS-1:0] led
);

    localparam logic [N_LEDS-1:0] POS_BOT = N_LEDS'(1);
    localparam logic [N_LEDS-1:0] POS_TOP = N_LEDS'(1) << (N_LEDS - 1);
    localparam cfg_t CFG_RST = '{mode: MODE_OFF, prescale: CFG_W'(PRE_W'(PRE_RST)), duty: '0};

    cfg_t              act_q, act_d;
    cfg_t              pend_q, pend_d;
    logic              pend_vld_q, pend_vld_d;
    logic [N_LEDS-1:0] cnt_q, cnt_d;
    logic [N_LEDS-1:0] pos_q, pos_d, pos_step;
    logic              dir_q, dir_d, dir_step;
    logic [PWM_W-1:0]  pwm_q, pwm_d;
    logic [N_LEDS-1:0] led_q, led_d;
    logic              xfer;
    logic              apply;

    assign cfg_ready = ~pend_vld_q;
    assign xfer      = cfg_valid & cfg_ready;
    // pend_vld_q is registered, so a tick in the transfer cycle itself cannot apply.
    assign apply     = pend_vld_q & tick;
    assign led       = led_q;

    led_prescaler #(
        .PRE_W(PRE_W)
    ) u_prescaler (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .restart_i (apply),
        .prescale_i(act_q.prescale),
        .tick_o    (tick)
    );

    // Bounce between the end bits; each end is visited once per sweep.
    always_comb begin
        pos_step = pos_q;
        dir_step = dir_q;
        if (N_LEDS > 1) begin
            if (dir_q == DIR_UP) begin
                pos_step = pos_q << 1;
                if (pos_step == POS_TOP) dir_step = DIR_DOWN;
            end else begin
                pos_step = pos_q >> 1;
                if (pos_step == POS_BOT) dir_step = DIR_UP;
            end
        end
    end

    always_comb begin
        act_d      = act_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        cnt_d      = tick ? cnt_q + N_LEDS'(1) : cnt_q;
        pwm_d      = pwm_q + PWM_W'(1);
        pos_d      = tick ? pos_step : pos_q;
        dir_d      = tick ? dir_step : dir_q;

        if (xfer) begin
            pend_vld_d = 1'b1;
            pend_d     = '{mode: mode_t'(cfg_mode), prescale: CFG_W'(cfg_prescale), duty: CFG_W'(cfg_duty)};
        end

        if (apply) begin
            pend_vld_d = 1'b0;
            act_d      = pend_q;
            if (pend_q.mode != act_q.mode) begin
                pos_d = POS_BOT;
                dir_d = DIR_UP;
            end
        end

        case (act_q.mode)
            MODE_COUNT: led_d = cnt_q;
            MODE_PWM:   led_d = {N_LEDS{CFG_W'(pwm_q) < act_q.duty}};
            MODE_SCAN:  led_d = pos_q;
            default:    led_d = '0;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            act_q      <= CFG_RST;
            pend_q     <= CFG_RST;
            pend_vld_q <= 1'b0;
            cnt_q      <= '0;
            pwm_q      <= '0;
            pos_q      <= POS_BOT;
            dir_q      <= DIR_UP;
            led_q      <= '0;
        end else begin
            act_q      <= act_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            cnt_q      <= cnt_d;
            pwm_q      <= pwm_d;
            pos_q      <= pos_d;
            dir_q      <= dir_d;
            led_q      <= led_d;
        end
    end

endmodule

// File: tb/tb_led_ctrl.sv
// Bench for led_ctrl: directed vector tables and corner sequences plus random config traffic,
// with every cycle compared against an arithmetic reference model.
module tb_led_ctrl;

    localparam int N    = 8;
    localparam int PW   = 24;
    localparam int DW   = 8;
    localparam int PRST = 20;

    logic          aclk;
    logic          aresetn;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [1:0]    cfg_mode;
    logic [PW-1:0] cfg_prescale;
    logic [DW-1:0] cfg_duty;
    logic          tick;
    logic [N-1:0]  led;

    int n_checks = 0;
    int n_fail   = 0;

    led_ctrl #(
        .N_LEDS (N),
        .PRE_W  (PW),
        .PWM_W  (DW),
        .PRE_RST(PRST)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_mode    (cfg_mode),
        .cfg_prescale(cfg_prescale),
        .cfg_duty    (cfg_duty),
        .tick        (tick),
        .led         (led)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // ---------------- reference model ----------------
    int           m_mode, m_prescale, m_duty, m_pre, m_cnt, m_pwm, m_k;
    int           p_mode, p_prescale, p_duty;
    bit           m_pend, m_tk, m_ap, m_xf;
    logic [N-1:0] m_led;

    // Scan position after k steps from bit 0: triangle wave of period 2(N-1).
    function automatic int scan_idx(input int k);
        int p;
        int r;
        if (N == 1) return 0;
        p = 2 * (N - 1);
        r = k % p;
        return (r < N) ? r : p - r;
    endfunction

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_mode = 0; m_prescale = PRST; m_duty = 0; m_pre = 0;
            m_cnt = 0; m_pwm = 0; m_k = 0; m_pend = 0; m_led = '0;
        end else begin
            m_tk = (m_pre == m_prescale);
            m_xf = cfg_valid && !m_pend;
            m_ap = m_pend && m_tk;
            case (m_mode)
                1:       m_led = N'(m_cnt);
                2:       m_led = (m_pwm < m_duty) ? '1 : '0;
                3:       m_led = N'(1) << scan_idx(m_k);
                default: m_led = '0;
            endcase
            if (m_tk) begin
                m_cnt = (m_cnt + 1) % (1 << N);
                m_k   = m_k + 1;
            end
            m_pwm = (m_pwm + 1) % (1 << DW);
            m_pre = m_tk ? 0 : m_pre + 1;
            if (m_ap) begin
                if (p_mode != m_mode) m_k = 0;
                m_mode = p_mode; m_prescale = p_prescale; m_duty = p_duty;
                m_pend = 0;
            end
            if (m_xf) begin
                m_pend = 1;
                p_mode = int'(cfg_mode); p_prescale = int'(cfg_prescale); p_duty = int'(cfg_duty);
            end
        end
    end

    always @(negedge aclk) begin
        if (aresetn) begin
            n_checks++;
            if (led !== m_led || tick !== 1'(m_pre == m_prescale) || cfg_ready !== 1'(!m_pend)) begin
                n_fail++;
                $display("FAIL model t=%0t led=%h want %h tick=%b want %b ready=%b want %b",
                         $time, led, m_led, tick, 1'(m_pre == m_prescale), cfg_ready, 1'(!m_pend));
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic send_cfg(input int m, input int p, input int d);
        int w;
        w = 0;
        while (cfg_ready !== 1'b1 && w < 400) begin
            @(negedge aclk);
            w++;
        end
        check("send_ready", cfg_ready, 1);
        cfg_valid = 1'b1; cfg_mode = 2'(m); cfg_prescale = PW'(p); cfg_duty = DW'(d);
        @(posedge aclk);
        #1;
        cfg_valid = 1'b0; cfg_mode = 2'($urandom); cfg_prescale = PW'($urandom); cfg_duty = DW'($urandom);
    endtask

    task automatic wait_apply(output int cyc);
        cyc = 0;
        do begin
            @(negedge aclk);
            cyc++;
        end while (cfg_ready !== 1'b1 && cyc < 400);
        check("apply_seen", cfg_ready, 1);
    endtask

    typedef struct {
        int duty;
        int exp_on;
    } pwm_vec_t;

    pwm_vec_t     pv [5];
    logic [N-1:0] scan_exp [16];

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int first, cyc, low, prev_led, last_tick, bad_int, bad_step, wraps, nticks;
        int on_cnt, odd_cnt, w, bad_led, bad_rdy;

        pv[0] = '{duty: 0,   exp_on: 0};
        pv[1] = '{duty: 64,  exp_on: 64};
        pv[2] = '{duty: 1,   exp_on: 1};
        pv[3] = '{duty: 255, exp_on: 255};
        pv[4] = '{duty: 128, exp_on: 128};
        scan_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                     8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

        aresetn = 1'b0; cfg_valid = 1'b0; cfg_mode = '0; cfg_prescale = '0; cfg_duty = '0;

        // Reset state, then release and time the first tick.
        repeat (3) @(negedge aclk);
        check("rst_led", led, 0);
        check("rst_tick", tick, 0);
        check("rst_ready", cfg_ready, 1);
        @(posedge aclk);
        #1 aresetn = 1'b1;
        first = -1;
        for (int i = 0; i < PRST + 10 && first < 0; i++) begin
            @(negedge aclk);
            if (tick === 1'b1) first = i;
        end
        check("first_tick_cycle", first, PRST);
        check("idle_led", led, 0);

        // COUNT transferred in a tick cycle: waits a full prescale period.
        send_cfg(1, 3, 0);
        wait_apply(cyc);
        check("apply_after_coincident_tick", cyc, PRST + 2);
        @(negedge aclk);
        prev_led = int'(led); last_tick = -1; bad_int = 0; bad_step = 0; wraps = 0; nticks = 0;
        for (int i = 0; i < 1100; i++) begin
            @(negedge aclk);
            if (tick === 1'b1) begin
                if (last_tick >= 0 && i - last_tick != 4) bad_int++;
                last_tick = i;
                nticks++;
            end
            if (int'(led) != prev_led) begin
                if (int'(led) != (prev_led + 1) % 256) bad_step++;
                if (prev_led == 255 && led == 0) wraps++;
                prev_led = int'(led);
            end
        end
        check("count_tick_interval", bad_int, 0);
        check("count_tick_total", nticks, 275);
        check("count_step", bad_step, 0);
        check("count_wrap", wraps, 1);

        // Transfer coincident with a prescale-3 tick: applied at the following tick.
        for (w = 0; w < 10 && tick !== 1'b1; w++) @(negedge aclk);
        check("found_tick", tick, 1);
        send_cfg(1, 3, 0);
        wait_apply(cyc);
        check("coincident_p3_wait", cyc, 5);

        // cfg_valid held high: second config only taken after the first is applied.
        cfg_valid = 1'b1; cfg_mode = 2'd2; cfg_prescale = '0; cfg_duty = DW'(64);
        @(posedge aclk);
        #1;
        cfg_mode = 2'd3; cfg_prescale = '0; cfg_duty = '0;
        low = 0;
        do begin
            @(negedge aclk);
            if (cfg_ready !== 1'b1) low++;
        end while (cfg_ready !== 1'b1 && low < 20);
        check("hold_low_cycles", low, 3);
        @(negedge aclk);
        check("hold_second_taken", cfg_ready, 0);
        cfg_valid = 1'b0;
        @(negedge aclk);
        check("hold_second_applied", cfg_ready, 1);

        // PWM duty table at prescale 0.
        foreach (pv[i]) begin
            send_cfg(2, 0, pv[i].duty);
            wait_apply(cyc);
            @(negedge aclk);
            on_cnt = 0; odd_cnt = 0;
            for (int c = 0; c < 256; c++) begin
                @(negedge aclk);
                if (led === '1) on_cnt++;
                else if (led !== '0) odd_cnt++;
            end
            check($sformatf("pwm_on_duty%0d", pv[i].duty), on_cnt, pv[i].exp_on);
            check($sformatf("pwm_levels_duty%0d", pv[i].duty), odd_cnt, 0);
        end

        // SCAN entered from PWM: starts at bit 0 going up, one step per cycle.
        send_cfg(3, 0, 0);
        wait_apply(cyc);
        check("apply_p0_wait", cyc, 2);
        foreach (scan_exp[i]) begin
            @(negedge aclk);
            check($sformatf("scan_step%0d", i), led, scan_exp[i]);
        end

        // Reset while a config is pending: it must never take effect.
        send_cfg(1, 15, 0);
        wait_apply(cyc);
        send_cfg(3, 0, 0);
        repeat (2) @(negedge aclk);
        check("pending_before_reset", cfg_ready, 0);
        aresetn = 1'b0;
        repeat (2) @(negedge aclk);
        check("mid_reset_led", led, 0);
        aresetn = 1'b1;
        bad_led = 0; bad_rdy = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge aclk);
            if (led !== '0) bad_led++;
            if (cfg_ready !== 1'b1) bad_rdy++;
        end
        check("discard_led_off", bad_led, 0);
        check("discard_ready", bad_rdy, 0);

        // Random configuration traffic with one asynchronous reset pulse.
        for (int i = 0; i < 3000; i++) begin
            @(posedge aclk);
            #1;
            cfg_valid    = ($urandom_range(0, 3) == 0);
            cfg_mode     = 2'($urandom);
            cfg_prescale = PW'($urandom_range(0, 4));
            cfg_duty     = DW'($urandom);
            if (i == 1500) begin
                aresetn = 1'b0;
                @(negedge aclk);
                aresetn = 1'b1;
            end
        end
        cfg_valid = 1'b0;
        repeat (5) @(negedge aclk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
